// File: rtl/bus_txn_sched.sv
// Three-way bus scheduler (cpu/gpu/dbu) onto one memory-mapped slave, with gpu anti-starvation.
// Define BUS_TIMEOUT_EN to abort a stuck WAIT after TIMEOUT cycles.
module bus_txn_sched #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        gpu_req,
    input  logic        dbu_req,
    input  logic [31:0] cpu_a,
    input  logic [31:0] gpu_a,
    input  logic [31:0] dbu_a,
    input  logic [31:0] cpu_d,
    input  logic [31:0] gpu_d,
    input  logic [31:0] dbu_d,
    input  logic        cpu_we,
    input  logic        gpu_we,
    input  logic        dbu_we,
    output logic [31:0] cpu_spo,
    output logic [31:0] gpu_spo,
    output logic [31:0] dbu_spo,
    output logic        cpu_done,
    output logic        gpu_done,
    output logic        dbu_done,
    output logic [31:0] a,
    output logic [31:0] d,
    output logic        we,
    output logic        rd,
    input  logic [31:0] spo,
    input  logic        ready,
    output logic [1:0]  bus_owner,
    output logic        timeout_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
    } req_t;

    state_t           state, state_nxt;
    req_t [2:0]       port_req;
    req_t             sel;
    logic [1:0]       win;
    logic             wr_flag;
    logic [SW-1:0]    starve;
    logic [2:0]       done_r;
    logic [2:0][31:0] spo_r;
    logic             tmo;

    // Port index 0/1/2 = cpu/gpu/dbu; bus_owner code is index+1.
    assign port_req[0] = {cpu_a, cpu_d, cpu_we};
    assign port_req[1] = {gpu_a, gpu_d, gpu_we};
    assign port_req[2] = {dbu_a, dbu_d, dbu_we};

    assign {dbu_done, gpu_done, cpu_done} = done_r;
    assign cpu_spo = spo_r[0];
    assign gpu_spo = spo_r[1];
    assign dbu_spo = spo_r[2];

    always_comb begin
        win = 2'd0;
        if (gpu_req && starve == SLIM) win = 2'd2;
        else if (dbu_req)              win = 2'd3;
        else if (cpu_req)              win = 2'd1;
        else if (gpu_req)              win = 2'd2;
        case (win)
            2'd1:    sel = port_req[0];
            2'd2:    sel = port_req[1];
            2'd3:    sel = port_req[2];
            default: sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win != 2'd0) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (ready || tmo) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt;

    assign tmo = (state == WAIT) && !ready && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo;
            if (state == WAIT) tcnt <= tcnt + TW'(1);
            else               tcnt <= '0;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a         <= '0;
            d         <= '0;
            we        <= 1'b0;
            rd        <= 1'b0;
            wr_flag   <= 1'b0;
            bus_owner <= 2'd0;
            starve    <= '0;
            done_r    <= '0;
            spo_r     <= '0;
        end else begin
            we     <= 1'b0;
            rd     <= 1'b0;
            done_r <= '0;
            case (state)
                IDLE: if (win != 2'd0) begin
                    a         <= sel.a;
                    d         <= sel.d;
                    wr_flag   <= sel.we;
                    we        <= sel.we;
                    rd        <= !sel.we;
                    bus_owner <= win;
                end
                WAIT: if (ready || tmo) begin
                    for (int i = 0; i < 3; i++) begin
                        if (bus_owner == 2'(i + 1)) begin
                            done_r[i] <= 1'b1;
                            // ready wins over a coincident timeout
                            if (!ready)        spo_r[i] <= 32'hDEADBEEF;
                            else if (!wr_flag) spo_r[i] <= spo;
                        end
                    end
                end
                DONE: begin
                    bus_owner <= 2'd0;
                    if (bus_owner == 2'd2)             starve <= '0;
                    else if (gpu_req && starve != SLIM) starve <= starve + SW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_txn_sched.sv
// Scoreboard bench for bus_txn_sched: stimulus queues expected strobes/dones, a negedge monitor checks them.
module tb_bus_txn_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  rq;
    logic [31:0] req_a [3];
    logic [31:0] req_d [3];
    logic [2:0]  req_we;
    logic [31:0] spo_o [3];
    logic [2:0]  done_o;
    logic [31:0] a, d, spo;
    logic        we, rd, ready, timeout_err;
    logic [1:0]  bus_owner;

    bus_txn_sched #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(rq[0]), .gpu_req(rq[1]), .dbu_req(rq[2]),
        .cpu_a(req_a[0]), .gpu_a(req_a[1]), .dbu_a(req_a[2]),
        .cpu_d(req_d[0]), .gpu_d(req_d[1]), .dbu_d(req_d[2]),
        .cpu_we(req_we[0]), .gpu_we(req_we[1]), .dbu_we(req_we[2]),
        .cpu_spo(spo_o[0]), .gpu_spo(spo_o[1]), .dbu_spo(spo_o[2]),
        .cpu_done(done_o[0]), .gpu_done(done_o[1]), .dbu_done(done_o[2]),
        .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready),
        .bus_owner(bus_owner), .timeout_err(timeout_err)
    );

    typedef struct {int port; logic [31:0] a; logic [31:0] d; logic w; int cyc;} strb_t;
    typedef struct {int port; logic [31:0] spo; int cyc; logic tmo;} done_t;
    typedef struct {logic [31:0] a; logic [31:0] d; logic w;} txn_t;

    strb_t sq[$];
    done_t dq[$];
    txn_t  pq[3][$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    c;
    strb_t ms;
    done_t md;
    int    mp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input int p, input txn_t t);
        rq[p]     = 1'b1;
        req_a[p]  = t.a;
        req_d[p]  = t.d;
        req_we[p] = t.w;
    endtask

    task automatic post(input int p, input logic [31:0] pa, input logic [31:0] pd, input logic pw);
        txn_t t;
        t = '{pa, pd, pw};
        if (!rq[p]) load(p, t);
        else        pq[p].push_back(t);
    endtask

    task automatic exp_strb(input int p, input logic [31:0] ea, input logic [31:0] ed, input logic ew, input int ec);
        strb_t s;
        s = '{p, ea, ed, ew, ec};
        sq.push_back(s);
    endtask

    task automatic exp_done(input int p, input logic [31:0] es, input int ec, input logic et);
        done_t e;
        e = '{p, es, ec, et};
        dq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((sq.size() != 0 || dq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sq.size() + dq.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Requester model: drop req when done is seen, or reload the next queued transaction.
    always @(negedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (done_o[p]) begin
                rq[p] = 1'b0;
                if (pq[p].size() > 0) load(p, pq[p].pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd || we) begin
                if (sq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL strobe_unexpected: got a=%h rd=%b we=%b expected none", a, rd, we);
                end else begin
                    ms = sq.pop_front();
                    chk("strobe_owner", 32'(bus_owner), 32'(ms.port + 1));
                    chk("strobe_a", a, ms.a);
                    chk("strobe_d", d, ms.d);
                    chk("strobe_we_rd", 32'({we, rd}), ms.w ? 32'd2 : 32'd1);
                    chk("strobe_cycle", 32'(cyc), 32'(ms.cyc));
                end
            end
            if (done_o != 3'b000) begin
                chk("done_onehot", 32'($countones(done_o)), 32'd1);
                mp = done_o[0] ? 0 : (done_o[1] ? 1 : 2);
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got done=%b expected none", done_o);
                end else begin
                    md = dq.pop_front();
                    chk("done_port", 32'(mp), 32'(md.port));
                    chk("done_spo", spo_o[md.port], md.spo);
                    chk("done_cycle", 32'(cyc), 32'(md.cyc));
                    chk("done_owner", 32'(bus_owner), 32'(md.port + 1));
                    chk("done_timeout_err", 32'(timeout_err), 32'(md.tmo));
                end
            end else if (timeout_err) begin
                checks++; errors++;
                $display("FAIL timeout_err_alone: got 1 expected 0");
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rq = '0; req_we = '0; ready = 1'b1; spo = '0;
        for (int p = 0; p < 3; p++) begin req_a[p] = '0; req_d[p] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_a", a, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_we_rd", 32'({we, rd}), 32'd0);
        chk("rst_owner", 32'(bus_owner), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        for (int p = 0; p < 3; p++) chk("rst_spo", spo_o[p], 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single cpu read
        spo = 32'h12345678; c = cyc;
        post(0, 32'h80000010, 32'd0, 1'b0);
        exp_strb(0, 32'h80000010, 32'd0, 1'b0, c + 1);
        exp_done(0, 32'h12345678, c + 3, 1'b0);
        repeat (2) @(negedge clk);
        chk("t1_owner_wait", 32'(bus_owner), 32'd1);
        drain();
        chk("t1_owner_idle", 32'(bus_owner), 32'd0);

        // simultaneous requests: dbu, cpu, gpu
        spo = 32'h11110000; c = cyc;
        post(0, 32'h100, 32'd0, 1'b0);
        post(1, 32'h200, 32'd0, 1'b0);
        post(2, 32'h300, 32'hA5A5A5A5, 1'b1);
        exp_strb(2, 32'h300, 32'hA5A5A5A5, 1'b1, c + 1);  exp_done(2, 32'd0, c + 3, 1'b0);
        exp_strb(0, 32'h100, 32'd0, 1'b0, c + 5);         exp_done(0, 32'h11110000, c + 7, 1'b0);
        exp_strb(1, 32'h200, 32'd0, 1'b0, c + 9);         exp_done(1, 32'h11110000, c + 11, 1'b0);
        repeat (8) @(negedge clk);
        chk("t2_gpu_spo_held", spo_o[1], 32'd0);
        drain();

        // gpu starvation: forced win after 4 non-gpu completions
        spo = 32'h22220000; c = cyc;
        post(1, 32'h400, 32'd0, 1'b0);
        post(2, 32'h410, 32'hD0000001, 1'b1);
        post(2, 32'h420, 32'hD0000002, 1'b1);
        post(2, 32'h430, 32'hD0000003, 1'b1);
        post(0, 32'h440, 32'hC0000001, 1'b1);
        post(0, 32'h450, 32'd0, 1'b0);
        exp_strb(2, 32'h410, 32'hD0000001, 1'b1, c + 1);  exp_done(2, 32'd0, c + 3, 1'b0);
        exp_strb(2, 32'h420, 32'hD0000002, 1'b1, c + 5);  exp_done(2, 32'd0, c + 7, 1'b0);
        exp_strb(2, 32'h430, 32'hD0000003, 1'b1, c + 9);  exp_done(2, 32'd0, c + 11, 1'b0);
        exp_strb(0, 32'h440, 32'hC0000001, 1'b1, c + 13); exp_done(0, 32'h11110000, c + 15, 1'b0);
        exp_strb(1, 32'h400, 32'd0, 1'b0, c + 17);        exp_done(1, 32'h22220000, c + 19, 1'b0);
        exp_strb(0, 32'h450, 32'd0, 1'b0, c + 21);        exp_done(0, 32'h22220000, c + 23, 1'b0);
        drain();

        // starve counter back to 0: plain priority again
        spo = 32'h33330000; c = cyc;
        post(0, 32'h500, 32'd0, 1'b0);
        post(1, 32'h600, 32'h6, 1'b1);
        exp_strb(0, 32'h500, 32'd0, 1'b0, c + 1);  exp_done(0, 32'h33330000, c + 3, 1'b0);
        exp_strb(1, 32'h600, 32'h6, 1'b1, c + 5);  exp_done(1, 32'h22220000, c + 7, 1'b0);
        drain();

        // slave busy for 7 WAIT cycles
        spo = 32'h77777777; ready = 1'b0; c = cyc;
        post(1, 32'h700, 32'd0, 1'b0);
        exp_strb(1, 32'h700, 32'd0, 1'b0, c + 1);
        exp_done(1, 32'h77777777, c + 10, 1'b0);
        repeat (9) @(negedge clk);
        ready = 1'b1;
        drain();

        // reset during WAIT aborts the transaction
        spo = 32'h99999999; ready = 1'b0; c = cyc;
        post(0, 32'h900, 32'd0, 1'b0);
        exp_strb(0, 32'h900, 32'd0, 1'b0, c + 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        rq[0] = 1'b0;
        @(negedge clk);
        chk("t5_we_rd", 32'({we, rd}), 32'd0);
        chk("t5_owner", 32'(bus_owner), 32'd0);
        chk("t5_a", a, 32'd0);
        chk("t5_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_cpu_spo", spo_o[0], 32'd0);
        drain();

`ifdef BUS_TIMEOUT_EN
        // stuck slave: abort 16 cycles after WAIT entry
        spo = 32'h55555555; ready = 1'b0; c = cyc;
        post(0, 32'hA00, 32'd0, 1'b0);
        exp_strb(0, 32'hA00, 32'd0, 1'b0, c + 1);
        exp_done(0, 32'hDEADBEEF, c + 18, 1'b1);
        drain();
        ready = 1'b1;
        repeat (2) @(negedge clk);
`endif

        chk("end_pending", 32'(pq[0].size() + pq[1].size() + pq[2].size()), 32'd0);
        chk("end_req", 32'(rq), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
